// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline stages.
package mips_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        RUN = 1'b0,
        END = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: memory address/data, ID-side redirect and stall, and IF/ID outputs.
interface if_stage_if;
    import mips_pkg::*;

    logic [PC_W-1:0] pc_out;
    logic [31:0]     instr_in;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic [31:0]     if_id_instr;
    logic [PC_W-1:0] if_id_pc4;
    logic            if_id_valid;
    logic            fetch_done;
    logic [15:0]     fetch_cnt;
    logic [15:0]     bubble_cnt;

    modport master (
        output pc_out, if_id_instr, if_id_pc4, if_id_valid, fetch_done, fetch_cnt, bubble_cnt,
        input  instr_in, stall, branch_taken, branch_target, jump, jump_target
    );

    modport slave (
        input  pc_out, if_id_instr, if_id_pc4, if_id_valid, fetch_done, fetch_cnt, bubble_cnt,
        output instr_in, stall, branch_taken, branch_target, jump, jump_target
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble-insert has priority over load; otherwise holds.
module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            bubble,
    input  logic [31:0]     instr_d,
    input  logic [PC_W-1:0] pc4_d,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc4,
    output logic            valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, end-of-ROM state and
// issue counters; the fetched word is captured into an if_id_reg.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 1024
) (
    input  logic clk,
    input  logic reset,
    if_stage_if.master bus
);

    localparam logic [PC_W-1:0] ROM_LIMIT = PC_W'(ROM_BYTES);

    logic [PC_W-1:0] pc_q, pc_d;
    fetch_state_e    state_q, state_d;
    logic [15:0]     fetch_cnt_q, fetch_cnt_d;
    logic [15:0]     bubble_cnt_q, bubble_cnt_d;
    logic            redirect;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_plus4;
    logic            load;
    logic            bubble;

    assign redirect = (bus.jump | bus.branch_taken) & ~bus.stall;
    assign target   = (bus.jump ? bus.jump_target : bus.branch_target) & ~PC_W'(3);
    assign pc_plus4 = pc_q + PC_W'(4);

    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        load         = 1'b0;
        bubble       = 1'b0;
        if (!bus.stall) begin
            if (redirect) begin
                pc_d         = target;
                bubble       = 1'b1;
                bubble_cnt_d = bubble_cnt_q + 16'd1;
                state_d      = (target >= ROM_LIMIT) ? END : RUN;
            end else if (state_q == RUN) begin
                load        = 1'b1;
                fetch_cnt_d = fetch_cnt_q + 16'd1;
                // The last in-range word is still issued; the PC parks on it.
                if (pc_plus4 >= ROM_LIMIT) begin
                    state_d = END;
                end else begin
                    pc_d = pc_plus4;
                end
            end else begin
                bubble       = 1'b1;
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            state_q      <= RUN;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .bubble  (bubble),
        .instr_d (bus.instr_in),
        .pc4_d   (pc_plus4),
        .instr   (bus.if_id_instr),
        .pc4     (bus.if_id_pc4),
        .valid   (bus.if_id_valid)
    );

    assign bus.pc_out     = pc_q;
    assign bus.fetch_done = (state_q == END);
    assign bus.fetch_cnt  = fetch_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a ROM model returning 0xC0DE0000 ^ address.
module tb_if_stage;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (32'h0),
        .ROM_BYTES (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.instr_in = 32'hC0DE_0000 ^ bus.pc_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (bus.pc_out !== 32'h0) begin errors++;
            $display("FAIL reset_pc got %h want %h", bus.pc_out, 32'h0); end
        vectors++; if (bus.if_id_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", bus.if_id_valid); end
        vectors++; if (bus.fetch_cnt !== 16'd0 || bus.bubble_cnt !== 16'd0) begin errors++;
            $display("FAIL reset_cnt got %h/%h want 0/0", bus.fetch_cnt, bus.bubble_cnt); end
        vectors++; if (bus.fetch_done !== 1'b0) begin errors++;
            $display("FAIL reset_done got %b want 0", bus.fetch_done); end
        repeat (3) tick();
        vectors++; if (bus.pc_out !== 32'd12) begin errors++;
            $display("FAIL seq_pc got %h want %h", bus.pc_out, 32'd12); end
        vectors++; if (bus.if_id_pc4 !== 32'd12) begin errors++;
            $display("FAIL seq_pc4 got %h want %h", bus.if_id_pc4, 32'd12); end
        vectors++; if (bus.fetch_cnt !== 16'd3) begin errors++;
            $display("FAIL seq_cnt got %0d want 3", bus.fetch_cnt); end
        vectors++; if (bus.if_id_instr !== 32'hC0DE_0008 || bus.if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_instr got %h/%b want c0de0008/1", bus.if_id_instr,
                     bus.if_id_valid); end
    endtask

    task automatic test_branch();
        apply_reset();
        tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h10;
        tick();
        bus.branch_taken = 1'b0;
        vectors++; if (bus.pc_out !== 32'h10) begin errors++;
            $display("FAIL br_pc got %h want 10", bus.pc_out); end
        vectors++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin errors++;
            $display("FAIL br_bubble got %b/%h want 0/0", bus.if_id_valid, bus.if_id_instr); end
        vectors++; if (bus.bubble_cnt !== 16'd1) begin errors++;
            $display("FAIL br_bcnt got %0d want 1", bus.bubble_cnt); end
        tick();
        vectors++; if (bus.if_id_instr !== 32'hC0DE_0010) begin errors++;
            $display("FAIL br_instr got %h want c0de0010", bus.if_id_instr); end
        vectors++; if (bus.if_id_pc4 !== 32'h14 || bus.fetch_cnt !== 16'd2) begin errors++;
            $display("FAIL br_pc4 got %h/%0d want 14/2", bus.if_id_pc4, bus.fetch_cnt); end
    endtask

    task automatic test_stall();
        apply_reset();
        repeat (2) tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (bus.pc_out !== 32'd8 || bus.if_id_pc4 !== 32'd8) begin errors++;
                $display("FAIL stall_hold got %h/%h want 8/8", bus.pc_out, bus.if_id_pc4); end
            vectors++; if (bus.fetch_cnt !== 16'd2 || bus.if_id_instr !== 32'hC0DE_0004) begin
                errors++;
                $display("FAIL stall_cnt got %0d/%h want 2/c0de0004", bus.fetch_cnt,
                         bus.if_id_instr); end
        end
        bus.stall = 1'b0;
        tick();
        vectors++; if (bus.pc_out !== 32'd12 || bus.if_id_pc4 !== 32'd12) begin errors++;
            $display("FAIL stall_rel got %h/%h want c/c", bus.pc_out, bus.if_id_pc4); end
        vectors++; if (bus.fetch_cnt !== 16'd3 || bus.bubble_cnt !== 16'd0) begin errors++;
            $display("FAIL stall_relcnt got %0d/%0d want 3/0", bus.fetch_cnt, bus.bubble_cnt); end
    endtask

    task automatic test_stall_jump();
        apply_reset();
        tick();
        bus.stall       = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_target = 32'h20;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h30;
        tick();
        vectors++; if (bus.pc_out !== 32'h4 || bus.bubble_cnt !== 16'd0) begin errors++;
            $display("FAIL sj_ignore got %h/%0d want 4/0", bus.pc_out, bus.bubble_cnt); end
        bus.stall = 1'b0;
        tick();
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        vectors++; if (bus.pc_out !== 32'h20) begin errors++;
            $display("FAIL sj_pc got %h want 20 (jump over branch)", bus.pc_out); end
        vectors++; if (bus.bubble_cnt !== 16'd1 || bus.if_id_valid !== 1'b0) begin errors++;
            $display("FAIL sj_bubble got %0d/%b want 1/0", bus.bubble_cnt, bus.if_id_valid); end
        tick();
        vectors++; if (bus.if_id_instr !== 32'hC0DE_0020 || bus.if_id_pc4 !== 32'h24) begin
            errors++;
            $display("FAIL sj_instr got %h/%h want c0de0020/24", bus.if_id_instr,
                     bus.if_id_pc4); end
    endtask

    task automatic test_end();
        apply_reset();
        repeat (255) tick();
        vectors++; if (bus.pc_out !== 32'h3FC || bus.fetch_done !== 1'b0) begin errors++;
            $display("FAIL end_pre got %h/%b want 3fc/0", bus.pc_out, bus.fetch_done); end
        tick();
        vectors++; if (bus.fetch_done !== 1'b1 || bus.pc_out !== 32'h3FC) begin errors++;
            $display("FAIL end_enter got %b/%h want 1/3fc", bus.fetch_done, bus.pc_out); end
        vectors++; if (bus.if_id_instr !== 32'hC0DE_03FC || bus.if_id_pc4 !== 32'h400 ||
                       bus.fetch_cnt !== 16'd256) begin errors++;
            $display("FAIL end_last got %h/%h/%0d want c0de03fc/400/256", bus.if_id_instr,
                     bus.if_id_pc4, bus.fetch_cnt); end
        repeat (2) tick();
        vectors++; if (bus.bubble_cnt !== 16'd2 || bus.if_id_valid !== 1'b0 ||
                       bus.pc_out !== 32'h3FC) begin errors++;
            $display("FAIL end_bubbles got %0d/%b/%h want 2/0/3fc", bus.bubble_cnt,
                     bus.if_id_valid, bus.pc_out); end
        bus.stall = 1'b1;
        tick();
        bus.stall = 1'b0;
        vectors++; if (bus.bubble_cnt !== 16'd2) begin errors++;
            $display("FAIL end_stall got %0d want 2", bus.bubble_cnt); end
        bus.jump        = 1'b1;
        bus.jump_target = 32'h3;
        tick();
        bus.jump = 1'b0;
        vectors++; if (bus.pc_out !== 32'h0 || bus.fetch_done !== 1'b0 ||
                       bus.bubble_cnt !== 16'd3) begin errors++;
            $display("FAIL end_exit got %h/%b/%0d want 0/0/3", bus.pc_out, bus.fetch_done,
                     bus.bubble_cnt); end
        tick();
        vectors++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc4 !== 32'h4) begin errors++;
            $display("FAIL end_resume got %b/%h want 1/4", bus.if_id_valid, bus.if_id_pc4); end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h800;
        tick();
        vectors++; if (bus.fetch_done !== 1'b1 || bus.pc_out !== 32'h800) begin errors++;
            $display("FAIL oor_br got %b/%h want 1/800", bus.fetch_done, bus.pc_out); end
        bus.branch_target = 32'h900;
        tick();
        bus.branch_taken = 1'b0;
        vectors++; if (bus.fetch_done !== 1'b1 || bus.pc_out !== 32'h900) begin errors++;
            $display("FAIL oor_end got %b/%h want 1/900", bus.fetch_done, bus.pc_out); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (16) tick();
        vectors++; if (bus.pc_out !== 32'h40 || bus.fetch_cnt !== 16'd16) begin errors++;
            $display("FAIL ar_pre got %h/%0d want 40/16", bus.pc_out, bus.fetch_cnt); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (bus.pc_out !== 32'h0 || bus.fetch_cnt !== 16'd0 ||
                       bus.bubble_cnt !== 16'd0) begin errors++;
            $display("FAIL ar_state got %h/%0d/%0d want 0/0/0", bus.pc_out, bus.fetch_cnt,
                     bus.bubble_cnt); end
        vectors++; if (bus.if_id_instr !== 32'h0 || bus.if_id_pc4 !== 32'h0 ||
                       bus.if_id_valid !== 1'b0 || bus.fetch_done !== 1'b0) begin errors++;
            $display("FAIL ar_ifid got %h/%h/%b/%b want 0/0/0/0", bus.if_id_instr,
                     bus.if_id_pc4, bus.if_id_valid, bus.fetch_done); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        vectors++; if (bus.pc_out !== 32'h4 || bus.if_id_instr !== 32'hC0DE_0000 ||
                       bus.if_id_valid !== 1'b1) begin errors++;
            $display("FAIL ar_first got %h/%h/%b want 4/c0de0000/1", bus.pc_out,
                     bus.if_id_instr, bus.if_id_valid); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        test_reset();
        test_branch();
        test_stall();
        test_stall_jump();
        test_end();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
